// File: rtl/apb_slave_mem_pkg.sv
// Shared types and helpers for the APB3 register-file completer apb_slave_mem.
// The optional error path is controlled by the APB_SLAVE_MEM_ERR_EN macro in the top.
package apb_slave_mem_pkg;

   localparam int WAIT_CNT_W = 4;
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              slverr;
   } resp_t;

   // Misaligned byte address or beyond the last implemented word.
   function automatic logic addr_is_err(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || (addr >= 32'(depth * 4));
   endfunction

endpackage

// File: rtl/apb_slave_mem_regfile.sv
// DEPTH x DATA_WIDTH word array: one write port, one registered read port, synchronous clear.
// Read data is zero on every edge where no read is requested.
module apb_slave_mem_regfile #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[waddr] <= wdata;
         end
         rdata <= re ? mem[raddr] : '0;
      end
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer with a word-addressed register file and fixed wait-state insertion.
// Define APB_SLAVE_MEM_ERR_EN to raise PSLVERR on misaligned / out-of-range addresses.
module apb_slave_mem
   import apb_slave_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t                  state;
   logic [WAIT_CNT_W-1:0]   cnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    ready_q;
   logic                    slverr_q;
   logic                    setup;
   logic                    complete;
   logic                    err;
   logic                    we;
   logic                    re;
   logic [IDX_W-1:0]        idx;
   logic [DATA_WIDTH-1:0]   rf_rdata;
   resp_t                   resp;

   assign setup    = PSEL && !PENABLE;
   assign complete = (state == WAIT) && PSEL && PENABLE && (cnt == '0);
   assign idx      = addr_q[IDX_W+1:2];

`ifdef APB_SLAVE_MEM_ERR_EN
   assign err = addr_is_err(32'(addr_q), DEPTH);
`else
   // Without error checking the low and high address bits are simply dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr_q;
   assign err = 1'b0;
`endif

   assign we = complete && write_q && !err;
   assign re = complete && !write_q && !err;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         ready_q  <= 1'b0;
         slverr_q <= 1'b0;
      end else begin
         ready_q  <= 1'b0;
         slverr_q <= 1'b0;
         // A setup phase is captured from every state; only the next-state choice differs.
         if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            cnt     <= WAIT_CNT_W'(WAIT_CYCLES);
         end
         case (state)
            IDLE: begin
               if (setup) state <= WAIT;
            end
            WAIT: begin
               if (!PSEL) begin
                  state <= IDLE;
               end else if (PENABLE) begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else begin
                     ready_q  <= 1'b1;
                     slverr_q <= err;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               state <= setup ? WAIT : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   apb_slave_mem_regfile #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_regfile (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .we    (we),
      .waddr (idx),
      .wdata (wdata_q),
      .re    (re),
      .raddr (idx),
      .rdata (rf_rdata)
   );

   assign resp    = '{rdata: rf_rdata, slverr: slverr_q};
   assign PRDATA  = resp.rdata;
   assign PSLVERR = resp.slverr;
   assign PREADY  = ready_q;

endmodule
